// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, queue entry layout and default widths for the fetch queue unit.
package fetch_pkg;
    localparam int ADDR_WIDTH_DEF  = 64;
    localparam int INSTR_WIDTH_DEF = 32;
    localparam int INSTR_BYTES     = INSTR_WIDTH_DEF / 8;
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALT} fetch_state_t;
    typedef struct packed {
        logic [INSTR_WIDTH_DEF-1:0] instr;
        logic [ADDR_WIDTH_DEF-1:0]  pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two synchronous FIFO of fetch entries; flush beats push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o
);
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: decoupled instruction fetch with one outstanding i-cache request,
// an instruction queue toward decode, branch redirect/squash and sticky halt on a zero word.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int QUEUE_DEPTH = 4,
    localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  entry,
    output logic                   icache_req_valid,
    output logic [ADDR_WIDTH-1:0]  icache_req_addr,
    input  logic                   icache_req_ready,
    input  logic                   icache_resp_valid,
    input  logic [INSTR_WIDTH-1:0] icache_resp_instr,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [ADDR_WIDTH-1:0]  id_npc,
    output logic [CW-1:0]          queue_count,
    output logic                   halt
);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_WIDTH / 8);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic                  squash_q, squash_d, halt_q, halt_d;
    logic                  push, pop, flush, req_fire;
    entry_t                head, push_data;

    // A halted unit ignores redirects entirely, including the flush.
    assign flush            = redirect_valid && !halt_q;
    assign icache_req_valid = !reset && state_q == S_FETCH && queue_count < CW'(QUEUE_DEPTH) && !redirect_valid;
    assign icache_req_addr  = fetch_pc_q;
    assign req_fire         = icache_req_valid && icache_req_ready;
    assign id_valid         = queue_count != '0;
    assign pop              = id_valid && id_ready;
    assign id_instr         = head.instr;
    assign id_pc            = head.pc;
    assign id_npc           = head.pc + STEP;
    assign halt             = halt_q;
    assign push_data        = '{instr: icache_resp_instr, pc: req_pc_q};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        squash_d   = squash_q;
        halt_d     = halt_q;
        push       = 1'b0;
        if (flush) begin
            fetch_pc_d = redirect_pc;
            squash_d   = state_q == S_WAIT && !icache_resp_valid;
            state_d    = (state_q == S_WAIT && !icache_resp_valid) ? S_WAIT : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: if (req_fire) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + STEP;
                    state_d    = S_WAIT;
                end
                S_WAIT: if (icache_resp_valid) begin
                    squash_d = 1'b0;
                    push     = !squash_q && icache_resp_instr != '0;
                    state_d  = (squash_q || icache_resp_instr != '0) ? S_FETCH : S_HALT;
                end
                default: halt_d = halt_q || queue_count == '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= entry;
            req_pc_q   <= '0;
            squash_q   <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            squash_q   <= squash_d;
            halt_q     <= halt_d;
        end
    end

    fetch_queue #(
        .entry_t(entry_t),
        .DEPTH  (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (queue_count)
    );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: randomized fetch/decode traffic against a queue-level reference model.
module tb_fetch_queue_unit;
    localparam int D = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic [63:0] entry = '0;
    logic        icache_req_valid, icache_req_ready = 1'b0;
    logic [63:0] icache_req_addr;
    logic        icache_resp_valid = 1'b0;
    logic [31:0] icache_resp_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [63:0] id_pc, id_npc;
    logic [2:0]  queue_count;
    logic        halt;

    fetch_queue_unit dut (
        .clk(clk), .reset(reset), .entry(entry),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
        .icache_resp_instr(icache_resp_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_npc(id_npc),
        .queue_count(queue_count), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [63:0] pc;
    } ent_t;

    ent_t        exp_q[$];
    logic [63:0] m_pc = '0, m_out_pc = '0, redir_tgt = '0, zero_addr = '1;
    bit          m_out, m_squash, m_halting, m_halt;
    bit          force_redir, force_ready;
    int          resp_cnt;
    logic [31:0] resp_word = '0;
    int          n_tests = 0, n_fail = 0;
    int          p_ready = 100, p_creq = 100, p_redir = 0, p_zero = 0, dly_lo = 1, dly_hi = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear(input logic [63:0] e);
        m_pc = e; m_out = 0; m_squash = 0; m_halting = 0; m_halt = 0;
        exp_q.delete();
        resp_cnt = 0;
    endtask

    task automatic do_reset(input logic [63:0] e);
        @(negedge clk);
        reset = 1; entry = e; redirect_valid = 0; id_ready = 0; icache_req_ready = 0; icache_resp_valid = 0;
        model_clear(e);
        @(negedge clk);
        icache_resp_valid = 1;
        icache_resp_instr = 32'h13;
        #1;
        chk("rst_req_valid", 64'(icache_req_valid), 0);
        chk("rst_req_addr", icache_req_addr, e);
        chk("rst_id_valid", 64'(id_valid), 0);
        chk("rst_count", 64'(queue_count), 0);
        chk("rst_halt", 64'(halt), 0);
    endtask

    function automatic logic [31:0] nz_word();
        logic [31:0] w = $urandom;
        return (w == 0) ? 32'h1 : w;
    endfunction

    task automatic cycle();
        bit exp_req, fire, do_pop, resp, was_halting;
        int sz;
        @(negedge clk);
        reset = 0;
        icache_resp_valid = resp_cnt == 1;
        icache_resp_instr = icache_resp_valid ? resp_word : $urandom;
        redirect_valid = force_redir || ($urandom_range(0, 99) < p_redir);
        redirect_pc = force_redir ? redir_tgt : ({$urandom, $urandom} & ~64'h3);
        id_ready = force_ready || ($urandom_range(0, 99) < p_ready);
        icache_req_ready = $urandom_range(0, 99) < p_creq;
        #1;
        exp_req = !m_out && !m_halting && exp_q.size() < D && !redirect_valid;
        chk("req_valid", 64'(icache_req_valid), 64'(exp_req));
        if (exp_req) chk("req_addr", icache_req_addr, m_pc);
        fire = exp_req && icache_req_ready;
        do_pop = exp_q.size() > 0 && id_ready;
        resp = icache_resp_valid;
        was_halting = m_halting;
        sz = exp_q.size();
        if (resp_cnt > 0) resp_cnt--;
        if (redirect_valid && !m_halt) begin
            exp_q.delete();
            m_pc = redirect_pc;
            if (m_out) begin
                if (resp) begin m_out = 0; m_squash = 0; end
                else m_squash = 1;
            end
            m_halting = 0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (was_halting && sz == 0) m_halt = 1;
            if (m_out && resp) begin
                m_out = 0;
                if (m_squash) m_squash = 0;
                else if (resp_word != 0) exp_q.push_back('{resp_word, m_out_pc});
                else m_halting = 1;
            end
            if (fire) begin
                m_out = 1;
                m_out_pc = m_pc;
                m_pc = m_pc + 64'd4;
                resp_cnt = $urandom_range(dly_lo, dly_hi);
                resp_word = (m_out_pc == zero_addr || $urandom_range(0, 99) < p_zero) ? 32'h0 : nz_word();
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        chk("count", 64'(queue_count), 64'(exp_q.size()));
        chk("halt", 64'(halt), 64'(m_halt));
        chk("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
        if (id_valid && exp_q.size() > 0) begin
            chk("id_pc", id_pc, exp_q[0].pc);
            chk("id_instr", 64'(id_instr), 64'(exp_q[0].w));
            chk("id_npc", id_npc, exp_q[0].pc + 64'd4);
        end
    end

    initial begin
        bit found;
        model_clear(0);
        do_reset(64'h1000);
        repeat (12) cycle();
        p_ready = 0;
        repeat (20) cycle();
        @(posedge clk); #1;
        chk("sat_count", 64'(queue_count), 4);
        p_ready = 100;
        repeat (12) cycle();
        dly_lo = 3; dly_hi = 3; p_ready = 50;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) if (m_out && resp_cnt > 1) found = 1; else cycle();
        chk("t3_wait", 64'(found), 1);
        force_redir = 1; redir_tgt = 64'h2000;
        cycle();
        force_redir = 0;
        @(posedge clk); #1;
        chk("t3_flush", 64'(queue_count), 0);
        dly_lo = 1; dly_hi = 1;
        repeat (10) cycle();
        dly_lo = 2; dly_hi = 2; p_ready = 20;
        found = 0;
        for (int i = 0; i < 60 && !found; i++)
            if (m_out && !m_squash && resp_cnt == 1 && exp_q.size() > 0) found = 1; else cycle();
        chk("t4_wait", 64'(found), 1);
        force_redir = 1; force_ready = 1; redir_tgt = 64'h3000;
        cycle();
        force_redir = 0; force_ready = 0; p_ready = 100;
        repeat (10) cycle();
        do_reset(64'h1000);
        zero_addr = 64'h1010; dly_lo = 1; dly_hi = 1; p_ready = 50;
        repeat (60) cycle();
        chk("t5_halt", 64'(halt), 1);
        force_redir = 1; redir_tgt = 64'h4000;
        repeat (3) cycle();
        force_redir = 0;
        chk("t5_halt_sticky", 64'(halt), 1);
        zero_addr = '1;
        do_reset(64'h1000);
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        p_ready = 100;
        repeat (10) cycle();
        p_ready = 70; p_creq = 70; p_redir = 5; p_zero = 2; dly_lo = 1; dly_hi = 3;
        for (int i = 0; i < 3000; i++)
            if ($urandom_range(0, 199) == 0 || (m_halt && $urandom_range(0, 9) == 0))
                do_reset({$urandom, $urandom} & ~64'h3);
            else
                cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
